// File: rtl/pcie_app_consumer.sv
// Rate-throttled 64-bit stream sink with a running checksum
// exposed through the app register map (253 rate, 254/255 checksum).
module pcie_app_consumer #(
  parameter int RATE_BITS = 8
) (
  input  logic        pcieClk_in,
  input  logic        reset_in,
  input  logic        cpuWrValid_in,
  input  logic [7:0]  cpuWrAddr_in,
  input  logic [31:0] cpuWrData_in,
  input  logic        cpuRdValid_in,
  input  logic [7:0]  cpuRdAddr_in,
  output logic [31:0] cpuRdData_out,
  output logic        cpuRdValid_out,
  input  logic [63:0] rxData_in,
  input  logic        rxValid_in,
  output logic        rxReady_out
);

  typedef enum logic {
    READY,
    THROTTLE
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [RATE_BITS-1:0] rate;
  logic [RATE_BITS-1:0] count;
  logic [RATE_BITS-1:0] count_nx;
  logic [63:0]          checksum;
  logic [63:0]          sum_base;
  logic [31:0]          shadow;
  logic [31:0]          rd_data;
  logic                 accept;
  logic                 wr_rate;
  logic                 wr_clr;
  logic                 rd_lsw;
  logic                 rd_hit;
  logic                 unused_wr_bits;

  assign accept  = rxValid_in & rxReady_out;
  assign wr_rate = cpuWrValid_in && (cpuWrAddr_in == 8'd253);
  assign wr_clr  = cpuWrValid_in && (cpuWrAddr_in == 8'd254);
  assign rd_lsw  = cpuRdValid_in && (cpuRdAddr_in == 8'd254);
  assign rd_hit  = cpuRdValid_in && (cpuRdAddr_in >= 8'd253);
  assign unused_wr_bits = ^cpuWrData_in;

  // Clear happens before the add so a same-cycle accept lands on zero
  assign sum_base = wr_clr ? 64'd0 : checksum;

  always_comb begin
    state_nx = state;
    count_nx = count;
    case (state)
      READY: begin
        if (accept && (rate != '0)) begin
          state_nx = THROTTLE;
          count_nx = rate;
        end
      end
      THROTTLE: begin
        count_nx = count - 1'b1;
        if (count <= 1) begin
          state_nx = READY;
        end
      end
      default: state_nx = READY;
    endcase
  end

  always_comb begin
    rd_data = 32'd0;
    case (cpuRdAddr_in)
      8'd253:  rd_data = 32'(rate);
      8'd254:  rd_data = checksum[31:0];
      8'd255:  rd_data = shadow;
      default: rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      state          <= READY;
      count          <= '0;
      rate           <= '0;
      checksum       <= 64'd0;
      shadow         <= 32'd0;
      rxReady_out    <= 1'b0;
      cpuRdValid_out <= 1'b0;
      cpuRdData_out  <= 32'd0;
    end else begin
      state       <= state_nx;
      count       <= count_nx;
      rxReady_out <= (state_nx == READY);
      if (wr_rate) begin
        rate <= cpuWrData_in[RATE_BITS-1:0];
      end
      checksum <= accept ? sum_base + rxData_in : sum_base;
      // A snapshot keeps the MSW coherent with the LSW just returned
      if (rd_lsw) begin
        shadow <= checksum[63:32];
      end else if (wr_clr) begin
        shadow <= 32'd0;
      end
      cpuRdValid_out <= rd_hit;
      if (rd_hit) begin
        cpuRdData_out <= rd_data;
      end
    end
  end

endmodule
